// File: rtl/spm_pkg.sv
// Shared types and helpers for the spm sequencer/collector.
package spm_pkg;

  // Controller states: accept, clear the multiplier, stream y, wait out
  // the multiplier latency, then present the product.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } spm_ctrl_state_e;

  // Counter must reach 2*width+lat-1, so size it for 2*width+lat values plus one.
  function automatic int spm_cnt_width(input int width, input int lat);
    return $clog2(2 * width + lat + 1);
  endfunction

endpackage

// File: rtl/spm_deser.sv
// LSB-first serial-to-parallel collector: each enabled cycle the new bit
// enters at the MSB and everything moves one place toward bit 0, so after
// 2*WIDTH enabled cycles the first bit received sits in bit 0.
module spm_deser #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [2*WIDTH-1:0]   data_out
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] r_data;
  logic [PW-1:0] w_data_next;

  // Per-bit source selection: top bit takes the serial input, others take their upper neighbour.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_bit
      if (gi == PW - 1) begin : g_top
        assign w_data_next[gi] = bit_in;
      end else begin : g_mid
        assign w_data_next[gi] = r_data[gi+1];
      end
    end
  endgenerate

  // Shift register, only advancing in capture cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (en) begin
      r_data <= w_data_next;
    end
  end

  assign data_out = r_data;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Operand sequencer and result collector around the spm serial-parallel
// multiplier. Holds x on the parallel port, streams sign-extended y
// LSB-first, and gathers the 2*WIDTH-bit product coming back serially.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 spm_rst,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  input  logic                 spm_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = spm_cnt_width(WIDTH, LAT);
  localparam logic [CW-1:0] RUN_LAST   = CW'(PW - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PW + LAT - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(LAT);

  spm_ctrl_state_e  r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_cap_win;
  logic             w_cap_en;
  logic             w_spm_y;

  // Product bits arrive LAT cycles behind the y bits, so the capture window
  // opens once the counter has advanced LAT places past the first RUN cycle.
  generate
    if (LAT == 0) begin : g_cap_nolat
      assign w_cap_win = 1'b1;
    end else begin : g_cap_lat
      assign w_cap_win = (r_cnt >= CAP_FIRST);
    end
  endgenerate

  assign w_cap_en = ((r_state == RUN) || (r_state == DRAIN)) && w_cap_win;

  // Serial operand: y bits in RUN, sign fill while draining, zero otherwise.
  always_comb begin
    w_spm_y = 1'b0;
    case (r_state)
      RUN:     w_spm_y = r_y_sh[0];
      DRAIN:   w_spm_y = r_y_sh[WIDTH-1];
      default: w_spm_y = 1'b0;
    endcase
  end

  // Control FSM with counter, operand registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y_sh      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= in_x;
            r_y_sh     <= in_y;
            r_in_ready <= 1'b0;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          // Arithmetic shift keeps replicating the sign bit for the upper half.
          r_y_sh <= {r_y_sh[WIDTH-1], r_y_sh[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == RUN_LAST) begin
            if (LAT == 0) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == DRAIN_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  spm_deser #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .en       (w_cap_en),
    .bit_in   (spm_p),
    .data_out (out_p)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign spm_x     = r_x;
  assign spm_y     = w_spm_y;
  assign spm_rst   = rst | (r_state == CLEAR);

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl (WIDTH=4, LAT=1) driving a behavioural serial-parallel
// multiplier; products are checked against a queue of signed x*y mod 256.
module tb_spm_seq_ctrl;

  localparam int W   = 4;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_x = '0;
  logic [W-1:0]   in_y = '0;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           spm_rst;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_p;

  logic rdy_dir   = 1'b1;
  logic rand_mode = 1'b0;
  logic rand_rdy  = 1'b0;
  assign out_ready = rand_mode ? rand_rdy : rdy_dir;

  int n_checks = 0;
  int n_err    = 0;
  int n_sent   = 0;
  int n_recv   = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  spm_seq_ctrl #(.WIDTH(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .spm_rst   (spm_rst),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p)
  );

  // Serial-parallel multiplier: carry-save partial sum, one product bit per
  // cycle, registered output (one cycle from y bit to product bit).
  int spm_acc;
  int spm_t;
  always_comb spm_t = spm_acc + (spm_y ? int'($signed(spm_x)) : 0);
  always_ff @(posedge clk) begin
    if (spm_rst) begin
      spm_acc <= 0;
      spm_p   <= 1'b0;
    end else begin
      spm_acc <= spm_t >>> 1;
      spm_p   <= spm_t[0];
    end
  end

  // Random consumer readiness, only used in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] gold(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair, wait (bounded) for acceptance, and record the expected product.
  // Returns one step after the accepting edge, i.e. in the CLEAR cycle.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int w;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(gold(x, y));
    n_sent++;
    #1;
    in_valid = 1'b0;
  endtask

  // Called in the cycle after accept (cycle 1); reports the cycle in which
  // out_valid rises and how many cycles spm_rst was high before it.
  task automatic wait_done(output int k, output int nrst);
    k    = 1;
    nrst = 0;
    while (!out_valid && k < 100) begin
      if (spm_rst) nrst++;
      tick();
      k++;
    end
  endtask

  // Scoreboard: every product handshake pops one expected value.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        n_recv++;
        $display("txn %0d p=%h exp=%h", n_recv, out_p, e);
        check("sb_p", out_p, e);
      end
    end
  end

  initial begin
    int k;
    int nrst;
    int w;

    // Reset state
    tick(); tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_spm_x", spm_x, 0);
    check("rst_spm_y", spm_y, 0);
    check("rst_spm_rst", spm_rst, 1);
    rst = 1'b0;
    tick();
    check("idle_spm_rst", spm_rst, 0);

    // 1: basic op, latency and single clear cycle
    rdy_dir = 1'b1;
    send(4'd3, 4'd5);
    check("t1_spm_x", spm_x, 3);
    wait_done(k, nrst);
    check("t1_lat", k, 11);
    check("t1_spm_rst_cycles", nrst, 1);
    check("t1_p", out_p, 8'h0F);
    tick();
    check("t1_idle", in_ready, 1);

    // 2: signed corners
    send(4'hD, 4'd5); wait_done(k, nrst); check("t2a_p", out_p, 8'hF1); tick();
    send(4'd7, 4'h8); wait_done(k, nrst); check("t2b_p", out_p, 8'hC8); tick();
    send(4'h8, 4'h8); wait_done(k, nrst); check("t2c_p", out_p, 8'h40); tick();

    // 3: backpressure in DONE
    rdy_dir = 1'b0;
    send(4'd3, 4'd5);
    wait_done(k, nrst);
    check("t3_lat", k, 11);
    for (int i = 0; i < 6; i++) begin
      check("t3_valid", out_valid, 1);
      check("t3_p", out_p, 8'h0F);
      check("t3_in_ready", in_ready, 0);
      tick();
    end
    rdy_dir = 1'b1;
    tick();
    check("t3_valid_drop", out_valid, 0);
    check("t3_idle", in_ready, 1);

    // 4: in_valid during RUN ignored; second pair taken after handshake
    send(4'd1, 4'd7);
    tick(); tick(); tick();
    in_valid = 1'b1;
    in_x     = 4'hE;
    in_y     = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_x", spm_x, 1);
      check("t4_busy", in_ready, 0);
    end
    send(4'hE, 4'd3);
    check("t4_second_x", spm_x, 4'hE);
    wait_done(k, nrst);
    check("t4_lat", k, 11);
    check("t4_p", out_p, 8'hFA);
    tick();

    // 5: reset in the fifth RUN cycle
    send(4'd6, 4'd6);
    tick(); tick(); tick(); tick(); tick();
    check("t5_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("t5_spm_rst", spm_rst, 1);
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_sent--;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_p", out_p, 0);
    send(4'd2, 4'hF);
    wait_done(k, nrst);
    check("t5_p", out_p, 8'hFE);
    tick();

    // 6: random pairs with random consumer readiness
    rand_mode = 1'b1;
    for (int i = 0; i < 500; i++) begin
      send(4'($urandom), 4'($urandom));
    end
    rand_mode = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    tick(); tick();
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_recv_count", n_recv, n_sent);
    check("t6_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
